// File: rtl/fetcher_pkg.sv
// Shared constants for the instruction fetch stage: opcode classes,
// FSM state encodings and the default reset PC.
package fetcher_pkg;

    localparam logic [6:0]  OPC_BRANCH       = 7'b1100011;
    localparam logic [6:0]  OPC_JAL          = 7'b1101111;
    localparam logic [6:0]  OPC_JALR         = 7'b1100111;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PREDICT = 2'd2,
        ISSUE   = 2'd3
    } state_t;

endpackage

// File: rtl/fetcher_imm.sv
// Purely combinational B/J immediate generation and opcode classification
// for a 32-bit RISC-V instruction word.
module imm_extract
    import fetcher_pkg::*;
(
    input  logic [31:0] i_inst,
    output logic [31:0] o_immB,
    output logic [31:0] o_immJ,
    output logic        o_isBranch,
    output logic        o_isJal,
    output logic        o_isJalr
);

    assign o_immB     = {{20{i_inst[31]}}, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign o_immJ     = {{12{i_inst[31]}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
    assign o_isBranch = (i_inst[6:0] == OPC_BRANCH);
    assign o_isJal    = (i_inst[6:0] == OPC_JAL);
    assign o_isJalr   = (i_inst[6:0] == OPC_JALR);

endmodule

// File: rtl/fetcher.sv
// Instruction fetch stage: fetch PC, memory request, optional branch prediction
// query and instruction-queue push. Prediction is enabled by FETCHER_PREDICT_EN.
module fetcher
    import fetcher_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        Mem_Req,
    output logic [31:0] Mem_Addr,
    input  logic        Mem_Ready,
    input  logic [31:0] Mem_Data,
    output logic [31:0] Pred_PC,
    output logic [31:0] Pred_Imm,
    input  logic [31:0] Predict_Jump,
    input  logic        IQ_Full,
    output logic        IQ_Push,
    output logic [31:0] IQ_Inst,
    output logic [31:0] IQ_PC,
    output logic        IQ_Pred_Taken,
    output logic [31:0] IQ_Pred_Target,
    input  logic        Flush,
    input  logic [31:0] Flush_PC
);

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_memAddr;
    logic        r_memReq;
    logic        r_iqPush;
    logic [31:0] r_iqInst;
    logic [31:0] r_iqPc;
    logic        r_iqTaken;
    logic [31:0] r_iqTarget;
    logic [31:0] r_predPc;
    logic [31:0] r_predImm;

    logic [31:0] w_decodeSrc;
    logic [31:0] w_immB;
    logic [31:0] w_immJ;
    logic        w_isBranch;
    logic        w_isJal;
    logic        w_isJalr;
    logic        w_toPredict;
    logic [31:0] w_pcPlus4;
    logic [31:0] w_target;
    logic        w_taken;
    logic        w_memReqNext;
    logic        w_iqPushNext;

    // Decode the arriving word while fetching, the latched word otherwise.
    assign w_decodeSrc = (r_state == FETCH) ? Mem_Data : r_inst;
    assign w_pcPlus4   = r_pc + 32'd4;

    imm_extract u_immExtract (
        .i_inst    (w_decodeSrc),
        .o_immB    (w_immB),
        .o_immJ    (w_immJ),
        .o_isBranch(w_isBranch),
        .o_isJal   (w_isJal),
        .o_isJalr  (w_isJalr)
    );

`ifdef FETCHER_PREDICT_EN
    assign w_toPredict = w_isBranch;
`else
    logic w_unusedPredict;
    assign w_toPredict     = 1'b0;
    assign w_unusedPredict = ^{Predict_Jump, w_immB, w_isBranch};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else if (rdy) begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (Flush) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (!IQ_Full) w_nextState = FETCH;
                FETCH:   if (Mem_Ready) w_nextState = w_toPredict ? PREDICT : ISSUE;
                PREDICT: w_nextState = ISSUE;
                ISSUE:   w_nextState = IDLE;
            endcase
        end
    end

    // Next-PC and prediction for the latched word; Predict_Jump is valid in ISSUE.
    always_comb begin
        w_target     = w_pcPlus4;
        w_taken      = 1'b0;
        if (w_isJal) begin
            w_target = r_pc + w_immJ;
            w_taken  = 1'b1;
        end
`ifdef FETCHER_PREDICT_EN
        else if (w_isBranch) begin
            w_target = Predict_Jump;
            w_taken  = (Predict_Jump != w_pcPlus4);
        end
`endif
        else if (w_isJalr) begin
            w_target = w_pcPlus4;
            w_taken  = 1'b0;
        end
        w_memReqNext = (w_nextState == FETCH);
        w_iqPushNext = (r_state == ISSUE) && !Flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_inst     <= 32'h0;
            r_memAddr  <= RESET_PC;
            r_memReq   <= 1'b0;
            r_iqPush   <= 1'b0;
            r_iqInst   <= 32'h0;
            r_iqPc     <= 32'h0;
            r_iqTaken  <= 1'b0;
            r_iqTarget <= 32'h0;
            r_predPc   <= 32'h0;
            r_predImm  <= 32'h0;
        end else if (rdy) begin
            r_memReq <= w_memReqNext;
            r_iqPush <= w_iqPushNext;
            if (Flush) begin
                r_pc <= Flush_PC;
            end else begin
                if (r_state == IDLE && !IQ_Full) begin
                    r_memAddr <= r_pc;
                end
                if (r_state == FETCH && Mem_Ready) begin
                    r_inst <= Mem_Data;
                    if (w_toPredict) begin
                        r_predPc  <= r_pc;
                        r_predImm <= w_immB;
                    end
                end
                if (r_state == ISSUE) begin
                    r_iqInst   <= r_inst;
                    r_iqPc     <= r_pc;
                    r_iqTaken  <= w_taken;
                    r_iqTarget <= w_target;
                    r_pc       <= w_target;
                end
            end
        end
    end

    assign Mem_Req        = r_memReq;
    assign Mem_Addr       = r_memAddr;
    assign Pred_PC        = r_predPc;
    assign Pred_Imm       = r_predImm;
    assign IQ_Push        = r_iqPush;
    assign IQ_Inst        = r_iqInst;
    assign IQ_PC          = r_iqPc;
    assign IQ_Pred_Taken  = r_iqTaken;
    assign IQ_Pred_Target = r_iqTarget;

endmodule

// File: tb/tb_fetcher.sv
// Self-checking bench for fetcher: directed vector table plus hand-written
// sequences for flush, queue-full, ready-stall and mid-fetch reset.
module tb_fetcher;

    localparam logic [31:0] ADDI = 32'h0010_0093;
    localparam logic [31:0] BEQ  = 32'hFE00_0CE3;
    localparam logic [31:0] JALP = 32'h0200_00EF;
    localparam logic [31:0] JALN = 32'hFF1F_F06F;
    localparam logic [31:0] JALR = 32'h0001_00E7;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        Mem_Req;
    logic [31:0] Mem_Addr;
    logic        Mem_Ready;
    logic [31:0] Mem_Data;
    logic [31:0] Pred_PC;
    logic [31:0] Pred_Imm;
    logic [31:0] Predict_Jump;
    logic        IQ_Full;
    logic        IQ_Push;
    logic [31:0] IQ_Inst;
    logic [31:0] IQ_PC;
    logic        IQ_Pred_Taken;
    logic [31:0] IQ_Pred_Target;
    logic        Flush;
    logic [31:0] Flush_PC;

    int          checks = 0;
    int          passed = 0;
    logic        memEn;
    logic [31:0] memWord;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] predJump;
        logic [31:0] expTarget;
        logic        expTaken;
        logic [3:0]  expCycles;
        logic        chkPred;
        logic [31:0] expPredPc;
        logic [31:0] expPredImm;
    } vec_t;

    vec_t vecs [7];

    fetcher #(.RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .Mem_Req       (Mem_Req),
        .Mem_Addr      (Mem_Addr),
        .Mem_Ready     (Mem_Ready),
        .Mem_Data      (Mem_Data),
        .Pred_PC       (Pred_PC),
        .Pred_Imm      (Pred_Imm),
        .Predict_Jump  (Predict_Jump),
        .IQ_Full       (IQ_Full),
        .IQ_Push       (IQ_Push),
        .IQ_Inst       (IQ_Inst),
        .IQ_PC         (IQ_PC),
        .IQ_Pred_Taken (IQ_Pred_Taken),
        .IQ_Pred_Target(IQ_Pred_Target),
        .Flush         (Flush),
        .Flush_PC      (Flush_PC)
    );

    always #5 clk = ~clk;

    // Single-cycle memory: answers any request visible in the current cycle.
    always @(negedge clk) begin
        #1;
        Mem_Ready = memEn & Mem_Req;
        Mem_Data  = memWord;
    end

    function automatic vec_t mkVec(input logic [31:0] pc, input logic [31:0] inst,
                                   input logic [31:0] pj, input logic [31:0] tgt,
                                   input logic tk, input logic [3:0] cyc, input logic chk,
                                   input logic [31:0] ppc, input logic [31:0] pimm);
        vec_t v;
        v.pc = pc; v.inst = inst; v.predJump = pj; v.expTarget = tgt; v.expTaken = tk;
        v.expCycles = cyc; v.chkPred = chk; v.expPredPc = ppc; v.expPredImm = pimm;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic waitMemReq(input string name);
        int n = 0;
        while (Mem_Req !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {31'b0, Mem_Req}, 32'd1);
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        int cyc = 0;
        Flush        = 1'b1;
        Flush_PC     = v.pc;
        memWord      = v.inst;
        Predict_Jump = v.predJump;
        @(negedge clk);
        Flush = 1'b0;
        while (IQ_Push !== 1'b1 && cyc < 12) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput($sformatf("vec%0d.push", idx), {31'b0, IQ_Push}, 32'd1);
        checkOutput($sformatf("vec%0d.cycles", idx), cyc, {28'b0, v.expCycles});
        checkOutput($sformatf("vec%0d.inst", idx), IQ_Inst, v.inst);
        checkOutput($sformatf("vec%0d.pc", idx), IQ_PC, v.pc);
        checkOutput($sformatf("vec%0d.taken", idx), {31'b0, IQ_Pred_Taken}, {31'b0, v.expTaken});
        checkOutput($sformatf("vec%0d.target", idx), IQ_Pred_Target, v.expTarget);
        if (v.chkPred) begin
            checkOutput($sformatf("vec%0d.predPc", idx), Pred_PC, v.expPredPc);
            checkOutput($sformatf("vec%0d.predImm", idx), Pred_Imm, v.expPredImm);
        end
        @(negedge clk);
        waitMemReq($sformatf("vec%0d.nextReq", idx));
        checkOutput($sformatf("vec%0d.nextAddr", idx), Mem_Addr, v.expTarget);
    endtask

    initial begin
        int nPush;
        rst = 1'b1; rdy = 1'b1; IQ_Full = 1'b0; Flush = 1'b0; Flush_PC = 32'h0;
        Predict_Jump = 32'h0; memEn = 1'b0; memWord = ADDI;

        vecs[0] = mkVec(32'h0000_0200, ADDI, 32'hDEAD_0000, 32'h0000_0204, 1'b0, 4'd3, 1'b0, 32'h0, 32'h0);
        vecs[1] = mkVec(32'h0000_0010, JALP, 32'hDEAD_0000, 32'h0000_0030, 1'b1, 4'd3, 1'b0, 32'h0, 32'h0);
`ifdef FETCHER_PREDICT_EN
        vecs[2] = mkVec(32'h0000_0040, BEQ, 32'h0000_0038, 32'h0000_0038, 1'b1, 4'd4, 1'b1, 32'h0000_0040, 32'hFFFF_FFF8);
        vecs[3] = mkVec(32'h0000_0080, BEQ, 32'h0000_0084, 32'h0000_0084, 1'b0, 4'd4, 1'b1, 32'h0000_0080, 32'hFFFF_FFF8);
`else
        vecs[2] = mkVec(32'h0000_0040, BEQ, 32'h0000_0038, 32'h0000_0044, 1'b0, 4'd3, 1'b1, 32'h0, 32'h0);
        vecs[3] = mkVec(32'h0000_0080, BEQ, 32'h0000_0084, 32'h0000_0084, 1'b0, 4'd3, 1'b1, 32'h0, 32'h0);
`endif
        vecs[4] = mkVec(32'hFFFF_FFFC, ADDI, 32'hDEAD_0000, 32'h0000_0000, 1'b0, 4'd3, 1'b0, 32'h0, 32'h0);
        vecs[5] = mkVec(32'h0000_0300, JALR, 32'hDEAD_0000, 32'h0000_0304, 1'b0, 4'd3, 1'b0, 32'h0, 32'h0);
        vecs[6] = mkVec(32'h0000_0100, JALN, 32'hDEAD_0000, 32'h0000_00F0, 1'b1, 4'd3, 1'b0, 32'h0, 32'h0);

        repeat (2) @(negedge clk);
        checkOutput("rst.memReq", {31'b0, Mem_Req}, 32'd0);
        checkOutput("rst.memAddr", Mem_Addr, 32'h0);
        checkOutput("rst.iqPush", {31'b0, IQ_Push}, 32'd0);
        checkOutput("rst.iqInst", IQ_Inst, 32'h0);
        checkOutput("rst.iqPc", IQ_PC, 32'h0);
        checkOutput("rst.iqTarget", {31'b0, IQ_Pred_Taken} | IQ_Pred_Target, 32'h0);
        checkOutput("rst.pred", Pred_PC | Pred_Imm, 32'h0);

        // Back-to-back ADDI fetches: one push every third cycle.
        memEn = 1'b1;
        rst   = 1'b0;
        nPush = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (IQ_Push === 1'b1) begin
                checkOutput("seq.pc", IQ_PC, 32'(4 * nPush));
                checkOutput("seq.cycle", k, 32'(3 * (nPush + 1)));
                checkOutput("seq.taken", {31'b0, IQ_Pred_Taken}, 32'd0);
                nPush++;
            end
        end
        checkOutput("seq.count", nPush, 32'd3);

        for (int i = 0; i < 7; i++) applyStimulus(i, vecs[i]);

        // Flush coincident with Mem_Ready: word dropped, refetch from Flush_PC.
        Flush = 1'b1; Flush_PC = 32'h0000_0100; memWord = ADDI;
        @(negedge clk);
        Flush = 1'b0;
        checkOutput("flushRdy.memReq", {31'b0, Mem_Req}, 32'd0);
        checkOutput("flushRdy.push", {31'b0, IQ_Push}, 32'd0);
        @(negedge clk);
        checkOutput("flushRdy.req", {31'b0, Mem_Req}, 32'd1);
        checkOutput("flushRdy.addr", Mem_Addr, 32'h0000_0100);

        // Flush while in ISSUE suppresses the pending push.
        @(negedge clk);
        Flush = 1'b1; Flush_PC = 32'h0000_0180;
        @(negedge clk);
        Flush = 1'b0;
        checkOutput("flushIssue.push", {31'b0, IQ_Push}, 32'd0);
        @(negedge clk);
        checkOutput("flushIssue.addr", Mem_Addr, 32'h0000_0180);

        // IQ_Full holds the stage in IDLE.
        memEn = 1'b0; Flush = 1'b1; Flush_PC = 32'h0000_0400; IQ_Full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            Flush = 1'b0;
            checkOutput($sformatf("full.hold%0d", i), {31'b0, Mem_Req}, 32'd0);
        end
        IQ_Full = 1'b0;
        @(negedge clk);
        checkOutput("full.release", {31'b0, Mem_Req}, 32'd1);
        checkOutput("full.addr", Mem_Addr, 32'h0000_0400);

        // rdy low mid-FETCH freezes everything, even with Mem_Ready present.
        rdy = 1'b0; memEn = 1'b1; memWord = ADDI;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("stall.req%0d", i), {31'b0, Mem_Req}, 32'd1);
            checkOutput($sformatf("stall.addr%0d", i), Mem_Addr, 32'h0000_0400);
            checkOutput($sformatf("stall.push%0d", i), {31'b0, IQ_Push}, 32'd0);
        end
        rdy = 1'b1;
        @(negedge clk);
        checkOutput("stall.noEarlyPush", {31'b0, IQ_Push}, 32'd0);
        @(negedge clk);
        checkOutput("stall.push", {31'b0, IQ_Push}, 32'd1);
        checkOutput("stall.pc", IQ_PC, 32'h0000_0400);
        checkOutput("stall.target", IQ_Pred_Target, 32'h0000_0404);

        // Reset during an outstanding fetch abandons it.
        @(negedge clk);
        checkOutput("midRst.req", {31'b0, Mem_Req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midRst.memReq", {31'b0, Mem_Req}, 32'd0);
        checkOutput("midRst.push", {31'b0, IQ_Push}, 32'd0);
        checkOutput("midRst.iqPc", IQ_PC, 32'h0);
        @(negedge clk);
        checkOutput("midRst.refetch", Mem_Addr, 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
